// File: rtl/codec_init_sequencer.sv
// Boot-time codec register loader: walks a fixed table of 16-bit words and issues each
// word as two single-byte WRITE requests (high, then low) through the i2c_controller handshake.
module codec_init_sequencer #(
    parameter logic [6:0] PERIPH_ADDR    = 7'h1A,
    parameter int         N_WORDS        = 8,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         IDX_W          = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_ctrl_ready,
    output logic             o_ctrl_enable,
    output logic             o_ctrl_mode,
    output logic [6:0]       o_ctrl_periph_addr,
    output logic [7:0]       o_ctrl_transmit_byte,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [IDX_W-1:0] o_word_index
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W:0]   LP_N_WORDS  = (IDX_W+1)'(N_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_REQ, S_WAIT_ACC, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t           r_state, w_state;
    logic             r_hb, w_hb;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_en, w_en;
    logic [7:0]       r_byte, w_byte;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_error, w_error;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [IDX_W:0]   w_idx_p1;
    logic [15:0]      w_word;
    logic             w_timeout;
    logic             w_advance;

    always_comb begin
        w_word = 16'h0000;
        case (r_idx)
            IDX_W'(0): w_word = 16'h1E00;
            IDX_W'(1): w_word = 16'h0C00;
            IDX_W'(2): w_word = 16'h0812;
            IDX_W'(3): w_word = 16'h0A00;
            IDX_W'(4): w_word = 16'h0E02;
            IDX_W'(5): w_word = 16'h1000;
            IDX_W'(6): w_word = 16'h0500;
            IDX_W'(7): w_word = 16'h1201;
            default:   w_word = 16'h0000;
        endcase
    end

    always_comb begin
        w_state   = r_state;
        w_hb      = r_hb;
        w_en      = r_en;
        w_byte    = r_byte;
        w_busy    = r_busy;
        w_done    = r_done;
        w_error   = r_error;
        w_idx     = r_idx;
        w_advance = 1'b0;
        w_timeout = (r_cnt == LP_TO_LAST);
        w_idx_p1  = {1'b0, r_idx} + (IDX_W+1)'(1);

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state = S_WAIT_RDY;
                    w_done  = 1'b0;
                    w_error = 1'b0;
                    w_idx   = '0;
                    w_hb    = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                // Byte only ever loads here, so it is settled before enable rises.
                w_byte = r_hb ? w_word[15:8] : w_word[7:0];
                if (i_ctrl_ready) begin
                    w_state = S_REQ;
                    w_en    = 1'b1;
                end else if (w_timeout) begin
                    w_state = S_ERROR;
                end
            end
            S_REQ: w_state = S_WAIT_ACC;
            S_WAIT_ACC: begin
                if (!i_ctrl_ready) begin
                    w_en    = 1'b0;
                    w_state = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state = S_ERROR;
                end
            end
            S_WAIT_DONE: begin
                if (i_ctrl_ready) begin
                    if (r_hb) begin
                        w_hb    = 1'b0;
                        w_state = S_WAIT_RDY;
                    end else if (GAP_CYCLES == 0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state = S_GAP;
                    end
                end else if (w_timeout) begin
                    w_state = S_ERROR;
                end
            end
            S_GAP: begin
                if (r_cnt == LP_GAP_LAST) w_advance = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_advance) begin
            w_idx = w_idx_p1[IDX_W-1:0];
            if (w_idx_p1 == LP_N_WORDS) begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_busy  = 1'b0;
            end else begin
                w_hb    = 1'b1;
                w_state = S_WAIT_RDY;
            end
        end

        if ((w_state == S_ERROR) && (r_state != S_ERROR)) begin
            w_en    = 1'b0;
            w_error = 1'b1;
            w_busy  = 1'b0;
        end

        // Per-state dwell counter; restarts on every state change.
        if ((w_state != r_state) || (r_state == S_IDLE) || (r_state == S_DONE) ||
            (r_state == S_ERROR))
            w_cnt = '0;
        else
            w_cnt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_hb    <= 1'b1;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_byte  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state;
            r_hb    <= w_hb;
            r_cnt   <= w_cnt;
            r_en    <= w_en;
            r_byte  <= w_byte;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_error <= w_error;
            r_idx   <= w_idx;
        end
    end

    assign o_ctrl_enable        = r_en;
    assign o_ctrl_mode          = 1'b1;
    assign o_ctrl_periph_addr   = PERIPH_ADDR;
    assign o_ctrl_transmit_byte = r_byte;
    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_error              = r_error;
    assign o_word_index         = r_idx;

endmodule
